// File: rtl/apb_bridge_nslv.sv
// Registered APB fabric bridge: one upstream completer fans out to NSLV downstream
// requesters selected by the top address bits, with unmapped-address and timeout errors.
module apb_bridge_nslv #(
    parameter int NSLV    = 4,
    parameter int AWIDTH  = 10,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     PCLK,
    input  logic                     PRESET_N,
    input  logic                     s_psel,
    input  logic                     s_penable,
    input  logic                     s_pwrite,
    input  logic [AWIDTH-1:0]        s_paddr,
    input  logic [DWIDTH-1:0]        s_pwdata,
    input  logic [DWIDTH/8-1:0]      s_pstrb,
    output logic [DWIDTH-1:0]        s_prdata,
    output logic                     s_pready,
    output logic                     s_pslverr,
    output logic [NSLV-1:0]          m_psel,
    output logic                     m_penable,
    output logic                     m_pwrite,
    output logic [AWIDTH-1:0]        m_paddr,
    output logic [DWIDTH-1:0]        m_pwdata,
    output logic [DWIDTH/8-1:0]      m_pstrb,
    input  logic [NSLV*DWIDTH-1:0]   m_prdata,
    input  logic [NSLV-1:0]          m_pready,
    input  logic [NSLV-1:0]          m_pslverr,
    output logic [15:0]              err_cnt,
    input  logic                     err_clr
);

    // state  | meaning
    // IDLE   | waiting for an upstream setup phase
    // SETUP  | downstream psel asserted, penable low
    // ACCESS | downstream penable high, waiting for pready or timeout
    // RESP   | one-cycle upstream completion with captured data/error

    localparam int SELW = $clog2(NSLV);
    localparam int SW   = DWIDTH / 8;
    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SELW:0]  NSLV_W = NSLV[SELW:0];
    localparam logic [TW-1:0]  TO_W   = TIMEOUT[TW-1:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t             state, state_nxt;
    logic [SELW-1:0]    idx, idx_nxt;
    logic [TW-1:0]      cnt, cnt_nxt;

    logic [NSLV-1:0]    psel_nxt;
    logic               penable_nxt;
    logic               pwrite_nxt;
    logic [AWIDTH-1:0]  paddr_nxt;
    logic [DWIDTH-1:0]  pwdata_nxt;
    logic [SW-1:0]      pstrb_nxt;
    logic [DWIDTH-1:0]  prdata_nxt;
    logic               pready_nxt;
    logic               pslverr_nxt;

    logic [SELW-1:0]    sel_idx;
    logic               sel_mapped;
    logic               sel_pready;
    logic               sel_pslverr;
    logic [DWIDTH-1:0]  sel_rdata;

    function automatic logic [NSLV-1:0] onehot(input logic [SELW-1:0] i);
        logic [NSLV-1:0] v;
        v = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (i == SELW'(k)) v[k] = 1'b1;
        end
        return v;
    endfunction

    assign sel_idx    = s_paddr[AWIDTH-1 -: SELW];
    assign sel_mapped = ({1'b0, sel_idx} < NSLV_W);

    // only the slave currently addressed is ever observed
    always_comb begin
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        sel_rdata   = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (idx == SELW'(i)) begin
                sel_pready  = m_pready[i];
                sel_pslverr = m_pslverr[i];
                sel_rdata   = m_prdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        psel_nxt    = '0;
        penable_nxt = 1'b0;
        pwrite_nxt  = m_pwrite;
        paddr_nxt   = m_paddr;
        pwdata_nxt  = m_pwdata;
        pstrb_nxt   = m_pstrb;
        prdata_nxt  = '0;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (s_psel && !s_penable) begin
                    pwrite_nxt = s_pwrite;
                    paddr_nxt  = s_paddr;
                    pwdata_nxt = s_pwdata;
                    pstrb_nxt  = s_pstrb;
                    idx_nxt    = sel_idx;
                    if (sel_mapped) begin
                        state_nxt = ST_SETUP;
                        psel_nxt  = onehot(sel_idx);
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt   = ST_RESP;
                        pready_nxt  = 1'b1;
                        pslverr_nxt = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_nxt   = ST_ACCESS;
                psel_nxt    = onehot(idx);
                penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (sel_pready) begin
                    state_nxt   = ST_RESP;
                    pready_nxt  = 1'b1;
                    prdata_nxt  = m_pwrite ? '0 : sel_rdata;
                    pslverr_nxt = sel_pslverr;
                end else if ((TIMEOUT != 0) && (cnt == TO_W)) begin
                    // abandon the hung slave; select drops with the response
                    state_nxt   = ST_RESP;
                    pready_nxt  = 1'b1;
                    pslverr_nxt = 1'b1;
                end else begin
                    psel_nxt    = onehot(idx);
                    penable_nxt = 1'b1;
                    cnt_nxt     = cnt + 1'b1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            m_psel    <= '0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            m_pstrb   <= '0;
            s_prdata  <= '0;
            s_pready  <= 1'b0;
            s_pslverr <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            m_psel    <= psel_nxt;
            m_penable <= penable_nxt;
            m_pwrite  <= pwrite_nxt;
            m_paddr   <= paddr_nxt;
            m_pwdata  <= pwdata_nxt;
            m_pstrb   <= pstrb_nxt;
            s_prdata  <= prdata_nxt;
            s_pready  <= pready_nxt;
            s_pslverr <= pslverr_nxt;
        end
    end

    // clear takes priority over a coincident error response
    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if ((state == ST_RESP) && s_pslverr && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// Directed bench for apb_bridge_nslv: a 4-slave/TIMEOUT=8 instance with a scripted
// slave model, and a 3-slave instance used for the unmapped-address case.
module tb_apb_bridge_nslv;

    logic        PCLK;
    logic        PRESET_N;
    logic        s_psel_a, s_psel_b, s_penable, s_pwrite;
    logic [9:0]  s_paddr;
    logic [31:0] s_pwdata;
    logic [3:0]  s_pstrb;

    logic [31:0]  a_prdata;
    logic         a_pready, a_pslverr;
    logic [3:0]   a_m_psel;
    logic         a_m_penable, a_m_pwrite;
    logic [9:0]   a_m_paddr;
    logic [31:0]  a_m_pwdata;
    logic [3:0]   a_m_pstrb;
    logic [127:0] a_m_prdata;
    logic [3:0]   a_m_pready, a_m_pslverr;
    logic [15:0]  a_err_cnt;
    logic         a_err_clr;

    logic [31:0]  b_prdata;
    logic         b_pready, b_pslverr;
    logic [2:0]   b_m_psel;
    logic         b_m_penable, b_m_pwrite;
    logic [9:0]   b_m_paddr;
    logic [31:0]  b_m_pwdata;
    logic [3:0]   b_m_pstrb;
    logic [95:0]  b_m_prdata;
    logic [2:0]   b_m_pready, b_m_pslverr;
    logic [15:0]  b_err_cnt;
    logic         b_err_clr;

    int          tests = 0;
    int          fails = 0;
    int          sl_wait [4];
    logic        sl_hang [4];
    logic        sl_err  [4];
    logic [31:0] sl_data [4];
    logic [7:0]  acnt;
    logic        b_psel_seen = 1'b0;

    logic [31:0] rd, pwdata_c1;
    logic        er;
    int          n;
    logic [3:0]  psel_c1, pstrb_c1, psel_end;
    logic [9:0]  paddr_c1;

    apb_bridge_nslv #(.NSLV(4), .AWIDTH(10), .DWIDTH(32), .TIMEOUT(8)) dut_a (
        .PCLK(PCLK), .PRESET_N(PRESET_N),
        .s_psel(s_psel_a), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_prdata(a_prdata), .s_pready(a_pready), .s_pslverr(a_pslverr),
        .m_psel(a_m_psel), .m_penable(a_m_penable), .m_pwrite(a_m_pwrite),
        .m_paddr(a_m_paddr), .m_pwdata(a_m_pwdata), .m_pstrb(a_m_pstrb),
        .m_prdata(a_m_prdata), .m_pready(a_m_pready), .m_pslverr(a_m_pslverr),
        .err_cnt(a_err_cnt), .err_clr(a_err_clr)
    );

    apb_bridge_nslv #(.NSLV(3), .AWIDTH(10), .DWIDTH(32), .TIMEOUT(0)) dut_b (
        .PCLK(PCLK), .PRESET_N(PRESET_N),
        .s_psel(s_psel_b), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_prdata(b_prdata), .s_pready(b_pready), .s_pslverr(b_pslverr),
        .m_psel(b_m_psel), .m_penable(b_m_penable), .m_pwrite(b_m_pwrite),
        .m_paddr(b_m_paddr), .m_pwdata(b_m_pwdata), .m_pstrb(b_m_pstrb),
        .m_prdata(b_m_prdata), .m_pready(b_m_pready), .m_pslverr(b_m_pslverr),
        .err_cnt(b_err_cnt), .err_clr(b_err_clr)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    assign b_m_prdata  = {3{32'h5555_5555}};
    assign b_m_pready  = 3'b111;
    assign b_m_pslverr = 3'b000;
    assign b_err_clr   = 1'b0;

    always @(posedge PCLK) acnt <= a_m_penable ? acnt + 8'd1 : 8'd0;
    always @(posedge PCLK) if (|b_m_psel) b_psel_seen <= 1'b1;

    // unselected slaves always claim ready+error so that listening to them would show
    always_comb begin
        a_m_pready  = '0;
        a_m_pslverr = '0;
        a_m_prdata  = '0;
        for (int i = 0; i < 4; i++) begin
            a_m_prdata[i*32 +: 32] = sl_data[i];
            if (!a_m_psel[i]) begin
                a_m_pready[i]  = 1'b1;
                a_m_pslverr[i] = 1'b1;
            end else if (a_m_penable && !sl_hang[i] && (int'(acnt) >= sl_wait[i])) begin
                a_m_pready[i]  = 1'b1;
                a_m_pslverr[i] = sl_err[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n counts cycles from the upstream setup cycle (C0) to the s_pready cycle
    task automatic xfer(input bit use_b, input logic [9:0] addr, input bit wr,
                        input logic [31:0] wd, input logic [3:0] st);
        @(posedge PCLK); #1;
        if (use_b) s_psel_b = 1'b1; else s_psel_a = 1'b1;
        s_penable = 1'b0; s_paddr = addr; s_pwrite = wr; s_pwdata = wd; s_pstrb = st;
        n = 0;
        @(posedge PCLK); #1;
        s_penable = 1'b1;
        n = 1;
        psel_c1   = use_b ? {1'b0, b_m_psel} : a_m_psel;
        paddr_c1  = use_b ? b_m_paddr  : a_m_paddr;
        pstrb_c1  = use_b ? b_m_pstrb  : a_m_pstrb;
        pwdata_c1 = use_b ? b_m_pwdata : a_m_pwdata;
        while (!(use_b ? b_pready : a_pready) && n < 60) begin
            @(posedge PCLK); #1;
            n++;
        end
        rd       = use_b ? b_prdata : a_prdata;
        er       = use_b ? b_pslverr : a_pslverr;
        psel_end = use_b ? {1'b0, b_m_psel} : a_m_psel;
        s_psel_a = 1'b0; s_psel_b = 1'b0; s_penable = 1'b0;
    endtask

    initial begin
        PRESET_N = 1'b0;
        s_psel_a = 1'b0; s_psel_b = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
        s_paddr = '0; s_pwdata = '0; s_pstrb = '0; a_err_clr = 1'b0;
        sl_wait = '{0, 0, 3, 0};
        sl_hang = '{1'b0, 1'b0, 1'b0, 1'b0};
        sl_err  = '{1'b0, 1'b0, 1'b0, 1'b0};
        sl_data = '{32'h0A0A_0A0A, 32'h1111_1111, 32'hDEAD_BEEF, 32'h3333_3333};

        #12;
        chk("rst_m_psel",   32'(a_m_psel),    32'h0);
        chk("rst_m_penable", 32'(a_m_penable), 32'h0);
        chk("rst_s_pready", 32'(a_pready),    32'h0);
        chk("rst_m_paddr",  32'(a_m_paddr),   32'h0);
        chk("rst_err_cnt",  32'(a_err_cnt),   32'h0);
        @(posedge PCLK); #1;
        PRESET_N = 1'b1;

        xfer(1'b0, 10'h104, 1'b1, 32'hA5A5_0001, 4'b0011);
        chk("wr_cycles",  32'(n),        32'd3);
        chk("wr_psel_c1", 32'(psel_c1),  32'h2);
        chk("wr_paddr",   32'(paddr_c1), 32'h104);
        chk("wr_pstrb",   32'(pstrb_c1), 32'h3);
        chk("wr_pwdata",  pwdata_c1,     32'hA5A5_0001);
        chk("wr_pslverr", 32'(er),       32'h0);
        chk("wr_prdata",  rd,            32'h0);

        xfer(1'b0, 10'h2F0, 1'b0, 32'h0, 4'b0000);
        chk("rd2_cycles",  32'(n),  32'd6);
        chk("rd2_prdata",  rd,      32'hDEAD_BEEF);
        chk("rd2_pslverr", 32'(er), 32'h0);

        xfer(1'b1, 10'h3FC, 1'b0, 32'h0, 4'b0000);
        chk("unm_cycles",  32'(n),       32'd1);
        chk("unm_pslverr", 32'(er),      32'h1);
        chk("unm_prdata",  rd,           32'h0);
        chk("unm_psel_c1", 32'(psel_c1), 32'h0);
        @(posedge PCLK); #1;
        chk("unm_err_cnt", 32'(b_err_cnt),   32'h1);
        chk("unm_psel_seen", 32'(b_psel_seen), 32'h0);

        sl_hang[0] = 1'b1;
        xfer(1'b0, 10'h010, 1'b0, 32'h0, 4'b0000);
        chk("to_cycles",   32'(n),        32'd11);
        chk("to_pslverr",  32'(er),       32'h1);
        chk("to_prdata",   rd,            32'h0);
        chk("to_psel_end", 32'(psel_end), 32'h0);
        sl_hang[0] = 1'b0;
        xfer(1'b0, 10'h100, 1'b0, 32'h0, 4'b0000);
        chk("b2b_cycles", 32'(n),  32'd3);
        chk("b2b_prdata", rd,      32'h1111_1111);
        chk("to_err_cnt", 32'(a_err_cnt), 32'h1);

        sl_err[3] = 1'b1;
        xfer(1'b0, 10'h300, 1'b0, 32'h0, 4'b0000);
        chk("se_cycles",  32'(n),  32'd3);
        chk("se_pslverr", 32'(er), 32'h1);
        chk("se_prdata",  rd,      32'h3333_3333);
        @(posedge PCLK); #1;
        chk("se_err_cnt", 32'(a_err_cnt), 32'h2);

        xfer(1'b0, 10'h300, 1'b0, 32'h0, 4'b0000);
        a_err_clr = 1'b1;
        @(posedge PCLK); #1;
        a_err_clr = 1'b0;
        chk("clr_wins", 32'(a_err_cnt), 32'h0);

        force dut_a.err_cnt = 16'hFFFF;
        @(posedge PCLK); #1;
        release dut_a.err_cnt;
        xfer(1'b0, 10'h300, 1'b0, 32'h0, 4'b0000);
        @(posedge PCLK); #1;
        chk("sat_err_cnt", 32'(a_err_cnt), 32'hFFFF);
        sl_err[3] = 1'b0;

        sl_hang[0] = 1'b1;
        @(posedge PCLK); #1;
        s_psel_a = 1'b1; s_penable = 1'b0; s_paddr = 10'h010; s_pwrite = 1'b0;
        @(posedge PCLK); #1;
        s_penable = 1'b1;
        @(posedge PCLK); #1;
        chk("ar_in_access", 32'(a_m_penable), 32'h1);
        #2 PRESET_N = 1'b0;
        #1;
        chk("ar_m_psel",    32'(a_m_psel),    32'h0);
        chk("ar_m_penable", 32'(a_m_penable), 32'h0);
        chk("ar_s_pready",  32'(a_pready),    32'h0);
        chk("ar_err_cnt",   32'(a_err_cnt),   32'h0);
        s_psel_a = 1'b0; s_penable = 1'b0;
        sl_hang[0] = 1'b0;
        @(posedge PCLK); #1;
        PRESET_N = 1'b1;
        xfer(1'b0, 10'h2F0, 1'b0, 32'h0, 4'b0000);
        chk("post_rst_cycles", 32'(n), 32'd6);
        chk("post_rst_prdata", rd,     32'hDEAD_BEEF);

        @(posedge PCLK); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
